// File: rtl/apb_req_arbiter_if.sv
// Signal bundle between apb_req_arbiter, its requesters and the shared master_apb.
// The master modport is the arbiter's view; slave is the requester/APB side.
interface apb_req_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic [DATA_WIDTH-1:0]         rdata;
   logic                          busy;
   logic                          transfer;
   logic                          READ_WRITE;
   logic [ADDR_WIDTH-1:0]         apb_write_paddr;
   logic [ADDR_WIDTH-1:0]         apb_read_paddr;
   logic [DATA_WIDTH-1:0]         apb_write_data;
   logic                          PSEL;
   logic                          PENABLE;
   logic                          PREADY;
   logic [DATA_WIDTH-1:0]         PRDATA;

   modport master (
      input  req, req_write, req_addr, req_wdata, PSEL, PENABLE, PREADY, PRDATA,
      output gnt, ack, rdata, busy, transfer, READ_WRITE,
             apb_write_paddr, apb_read_paddr, apb_write_data
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, PSEL, PENABLE, PREADY, PRDATA,
      input  gnt, ack, rdata, busy, transfer, READ_WRITE,
             apb_write_paddr, apb_read_paddr, apb_write_data
   );
endinterface

// File: rtl/apb_req_arbiter.sv
// Shares one master_apb between NUM_REQ requesters, one transaction at a time.
// Round robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module apb_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input logic               PCLK,
   input logic               PRESET,
   apb_req_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} state_e;

   state_e                state_q;
   logic [NUM_REQ-1:0]    gnt_q;
   logic [IDX_W-1:0]      gnt_idx_q;
   logic [NUM_REQ-1:0]    ack_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  transfer_q;

   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    cand;
   logic                  gnt_vld_d;
   logic [IDX_W-1:0]      gnt_idx_d;
   logic                  gnt_vld;
   logic                  gnt_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // The requester being acked this cycle still holds req; mask it so it cannot re-win at once.
   assign elig = bus.req & ~ack_q;

`ifdef ARB_FIXED_PRIO_EN
   assign cand = elig;
`else
   logic [IDX_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] above_ptr;

   // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
   always_comb begin
      above_ptr = '0;
      for (int i = 0; i < NUM_REQ; i++) above_ptr[i] = (i > int'(ptr_q));
      cand = ((elig & above_ptr) != '0) ? (elig & above_ptr) : elig;
   end
`endif

   always_comb begin
      gnt_vld_d = 1'b0;
      gnt_idx_d = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            gnt_vld_d = 1'b1;
            gnt_idx_d = IDX_W'(i);
         end
      end
   end

   assign gnt_vld   = |gnt_q;
   assign gnt_write = gnt_vld & bus.req_write[gnt_idx_q];
   assign sel_addr  = bus.req_addr[int'(gnt_idx_q) * ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_wdata = bus.req_wdata[int'(gnt_idx_q) * DATA_WIDTH +: DATA_WIDTH];

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         ack_q      <= '0;
         rdata_q    <= '0;
         transfer_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q      <= IDX_W'(NUM_REQ - 1);
`endif
      end else begin
         ack_q <= '0;
         unique case (state_q)
            ARB_IDLE: begin
               if (gnt_vld_d) begin
                  gnt_q      <= NUM_REQ'(1) << gnt_idx_d;
                  gnt_idx_q  <= gnt_idx_d;
                  transfer_q <= 1'b1;
                  state_q    <= ARB_REQ;
`ifndef ARB_FIXED_PRIO_EN
                  ptr_q      <= gnt_idx_d;
`endif
               end
            end
            ARB_REQ: begin
               if (bus.PSEL && !bus.PENABLE) begin
                  transfer_q <= 1'b0;
                  state_q    <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
                  ack_q   <= gnt_q;
                  gnt_q   <= '0;
                  state_q <= ARB_IDLE;
                  if (!gnt_write) rdata_q <= bus.PRDATA;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.gnt             = gnt_q;
   assign bus.ack             = ack_q;
   assign bus.rdata           = rdata_q;
   assign bus.busy            = (state_q != ARB_IDLE);
   assign bus.transfer        = transfer_q;
   assign bus.READ_WRITE      = gnt_write;
   assign bus.apb_write_paddr = gnt_write ? sel_addr : '0;
   assign bus.apb_read_paddr  = (gnt_vld && !gnt_write) ? sel_addr : '0;
   assign bus.apb_write_data  = gnt_write ? sel_wdata : '0;

   // At most one requester granted and at most one acked in any cycle.
   assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(gnt_q) && $onehot0(ack_q));
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one master_apb instance between NUM_REQ independent requesters.
- Accepts per-requester read/write requests and arbitrates round-robin, or fixed-priority when compiled that way.
- Drives the master's user-side controls (transfer, READ_WRITE, addresses, write data) and tracks the APB phase via PSEL/PENABLE/PREADY.
- Returns a one-cycle ack plus captured read data to the winning requester; one transaction in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, APB address width; matches the master.
- DATA_WIDTH, 32, APB data width; matches the master.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset.
- req  in  NUM_REQ  request level per requester; held until its ack.
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_WIDTH  address; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data; slice i belongs to requester i.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_WIDTH  read data; valid in the ack cycle of a read.
- busy  out  1  high when state is not ARB_IDLE.
- transfer  out  1  to master transfer.
- READ_WRITE  out  1  to master; req_write of the granted requester.
- apb_write_paddr  out  ADDR_WIDTH  granted address when writing, else 0.
- apb_read_paddr  out  ADDR_WIDTH  granted address when reading, else 0.
- apb_write_data  out  DATA_WIDTH  granted wdata when writing, else 0.
- PSEL  in  1  monitored from the master.
- PENABLE  in  1  monitored from the master.
- PREADY  in  1  monitored from the slave.
- PRDATA  in  DATA_WIDTH  monitored from the slave.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state ARB_IDLE, gnt=0, ack=0, rdata=0, transfer=0, rr pointer=NUM_REQ-1 (requester 0 wins first).
- State ARB_IDLE:
  - Eligible set = req & ~ack, so the requester acked this cycle is masked.
  - If the eligible set is non-zero: pick a winner, register gnt, set pointer=winner, go to ARB_REQ.
- State ARB_REQ:
  - transfer=1.
  - On PSEL & !PENABLE (master in SETUP), go to ARB_WAIT.
- State ARB_WAIT:
  - transfer=0, so the master returns to IDLE after ACCESS; no back-to-back APB transfers.
  - On PSEL & PENABLE & PREADY: register ack=gnt, rdata=PRDATA (reads only; writes leave rdata unchanged), clear gnt, go to ARB_IDLE.
  - Otherwise stay in ARB_WAIT; no timeout.
- Round robin: search starts at pointer+1 and wraps modulo NUM_REQ.
- Combinational outputs: READ_WRITE and addr/wdata are muxed from the registered gnt index; all are 0 when gnt=0.
- Latency, zero wait states: req seen in cycle 0, gnt/transfer high cycle 1, master SETUP cycle 2, ACCESS+PREADY cycle 3, ack cycle 4. Each PREADY-low cycle adds one cycle.
- Boundary conditions:
  - req dropped before grant: ignored.
  - req dropped after grant: transaction still completes; ack is still pulsed.
  - Requester inputs (write/addr/wdata) must stay stable while granted; the arbiter does not latch them.
  - New req arriving mid-transaction: waits; it is considered in the ack cycle at the earliest.
  - Simultaneous requests: exactly one grant.
  - Reset asserted mid-transaction: immediate return to reset values, no ack. The master must be reset by the same event.
  - Assertion: at most one gnt bit and one ack bit high per cycle.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer unused; the ack-cycle masking rule still applies.
- Undefined: round robin as described above.

Test Plan:
- Single read by requester 1 at addr 0x10, PRDATA=0xDEADBEEF, PREADY=1 -> gnt=0010 in cycles 1-3, apb_read_paddr=0x10, READ_WRITE=0, ack=0010 in cycle 4 with rdata=0xDEADBEEF.
- Write by requester 0, addr 0x22, data 0x12345678, PREADY low for 3 ACCESS cycles -> apb_write_paddr=0x22, apb_write_data=0x12345678 held; ack in cycle 7; rdata unchanged.
- All 4 requesters hold req continuously -> grant order 0,1,2,3,0; no requester is granted twice consecutively. With ARB_FIXED_PRIO_EN: order 0,1,2,3, each requester dropping req after its ack.
- Requester 2 asserts req in the ack cycle of requester 0 while requester 0 keeps req high that cycle -> next grant=0100.
- PRESET pulsed in ARB_WAIT -> next cycle gnt=0, transfer=0, ack=0, busy=0; a fresh request restarts with requester 0 eligible first.
- Requester 3 drops req after grant -> transfer completes and ack=1000 is still pulsed exactly once.
